// File: rtl/collision_pkg.sv
// Shared codes, screen limits and FSM states for the collision probe.
// Build option: COLLISION_HAZARD_EN enables water/lava/goo side codes.
package collision_pkg;

  localparam int MAP_COLS_DEF   = 40;
  localparam int TILE_SHIFT_DEF = 4;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_SOLID = 3'd1;
  localparam logic [2:0] TILE_WATER = 3'd2;
  localparam logic [2:0] TILE_LAVA  = 3'd3;
  localparam logic [2:0] TILE_GOO   = 3'd4;

  localparam logic [2:0] SIDE_SOLID = 3'd0;
  localparam logic [2:0] SIDE_FREE  = 3'd1;
  localparam logic [2:0] SIDE_WATER = 3'd2;
  localparam logic [2:0] SIDE_LAVA  = 3'd3;
  localparam logic [2:0] SIDE_GOO   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/collision_probe_tile_addr_calc.sv
// Combinational pixel-to-tile-map address translation with off-screen detection.
module tile_addr_calc
  import collision_pkg::*;
#(
  parameter int MAP_COLS   = MAP_COLS_DEF,
  parameter int TILE_SHIFT = TILE_SHIFT_DEF
) (
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic [10:0] o_addr,
  output logic        o_oob
);

  logic [10:0] w_row;
  logic [10:0] w_col;

  assign w_row = 11'(i_y >> TILE_SHIFT);
  assign w_col = 11'(i_x >> TILE_SHIFT);

  // 40 columns decomposes into 32 + 8, so no multiplier is needed
  generate
    if (MAP_COLS == 40) begin : g_shift
      assign o_addr = (w_row << 5) + (w_row << 3) + w_col;
    end else begin : g_mult
      assign o_addr = w_row * 11'(MAP_COLS) + w_col;
    end
  endgenerate

  assign o_oob = (i_x >= SCREEN_W) || (i_y >= SCREEN_H);

endmodule

// File: rtl/collision_probe.sv
// Probes eight tile-map points around a bounding box and reports per-side contact codes.
// Build option: COLLISION_HAZARD_EN enables water/lava/goo reporting (otherwise free).
module collision_probe
  import collision_pkg::*;
#(
  parameter int MAP_COLS   = MAP_COLS_DEF,
  parameter int TILE_SHIFT = TILE_SHIFT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  BallL,
  input  logic [9:0]  BallR,
  input  logic [9:0]  BallT,
  input  logic [9:0]  BallB,
  output logic [10:0] map_addr,
  input  logic [2:0]  map_data,
  output logic [2:0]  wLeft,
  output logic [2:0]  wRight,
  output logic [2:0]  wTop,
  output logic [2:0]  wBottom,
  output logic        busy,
  output logic        done
);

  state_e r_state;
  logic [2:0]  r_cnt_p0;
  logic [9:0]  r_box_l, r_box_r, r_box_t, r_box_b;
  logic        r_done;
  logic [3:0][2:0] r_side;

  logic        r_vld_p1, r_oob_p1;
  logic [2:0]  r_idx_p1;
  logic [10:0] r_addr_p1;

  logic        r_vld_p2, r_oob_p2;
  logic [2:0]  r_idx_p2;
  logic [3:0][2:0] r_acc;

  logic [9:0]  w_x, w_y;
  logic [10:0] w_addr;
  logic        w_oob;
  logic        w_accept;
  logic [2:0]  w_code_p2;
  logic [3:0][2:0] w_acc_nxt;

  function automatic logic [2:0] tile_to_side(input logic [2:0] t);
    logic [2:0] s;
    case (t)
      TILE_EMPTY: s = SIDE_FREE;
      TILE_SOLID: s = SIDE_SOLID;
`ifdef COLLISION_HAZARD_EN
      TILE_WATER: s = SIDE_WATER;
      TILE_LAVA:  s = SIDE_LAVA;
      TILE_GOO:   s = SIDE_GOO;
`else
      TILE_WATER, TILE_LAVA, TILE_GOO: s = SIDE_FREE;
`endif
      default:    s = SIDE_SOLID;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] side_rank(input logic [2:0] s);
    logic [2:0] r;
    case (s)
      SIDE_SOLID: r = 3'd4;
      SIDE_LAVA:  r = 3'd3;
      SIDE_WATER: r = 3'd2;
      SIDE_GOO:   r = 3'd1;
      default:    r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] side_merge(input logic [2:0] a, input logic [2:0] b);
    return (side_rank(b) > side_rank(a)) ? b : a;
  endfunction

  assign w_accept = (r_state == ST_IDLE) && start && !r_done;

  // Probe order: left pair, right pair, top pair, bottom pair
  always_comb begin
    w_x = r_box_l;
    w_y = r_box_t;
    case (r_cnt_p0)
      3'd0: begin w_x = r_box_l - 10'd1; w_y = r_box_t + 10'd1; end
      3'd1: begin w_x = r_box_l - 10'd1; w_y = r_box_b - 10'd1; end
      3'd2: begin w_x = r_box_r + 10'd1; w_y = r_box_t + 10'd1; end
      3'd3: begin w_x = r_box_r + 10'd1; w_y = r_box_b - 10'd1; end
      3'd4: begin w_x = r_box_l + 10'd1; w_y = r_box_t - 10'd1; end
      3'd5: begin w_x = r_box_r - 10'd1; w_y = r_box_t - 10'd1; end
      3'd6: begin w_x = r_box_l + 10'd1; w_y = r_box_b + 10'd1; end
      default: begin w_x = r_box_r - 10'd1; w_y = r_box_b + 10'd1; end
    endcase
  end

  tile_addr_calc #(
    .MAP_COLS   (MAP_COLS),
    .TILE_SHIFT (TILE_SHIFT)
  ) u_addr (
    .i_x    (w_x),
    .i_y    (w_y),
    .o_addr (w_addr),
    .o_oob  (w_oob)
  );

  assign w_code_p2 = r_oob_p2 ? SIDE_SOLID : tile_to_side(map_data);

  always_comb begin
    w_acc_nxt = r_acc;
    if (r_vld_p2) begin
      if (!r_idx_p2[0])
        w_acc_nxt[r_idx_p2[2:1]] = w_code_p2;
      else
        w_acc_nxt[r_idx_p2[2:1]] = side_merge(r_acc[r_idx_p2[2:1]], w_code_p2);
    end
  end

  // Stage p0 -> p1: sequencing, address issue and published results
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_cnt_p0  <= 3'd0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_addr_p1 <= 11'd0;
      r_done    <= 1'b0;
      r_side    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= r_vld_p1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_PROBE;
            r_cnt_p0 <= 3'd0;
          end
        end
        ST_PROBE: begin
          r_vld_p1  <= 1'b1;
          r_addr_p1 <= w_addr;
          r_cnt_p0  <= r_cnt_p0 + 3'd1;
          if (r_cnt_p0 == 3'd7) r_state <= ST_DRAIN;
        end
        ST_DRAIN: r_state <= ST_DONE;
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_side  <= w_acc_nxt;
        end
      endcase
    end
  end

  // Stage p1 -> p2: box capture and tag/accumulator datapath
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_box_l <= BallL;
      r_box_r <= BallR;
      r_box_t <= BallT;
      r_box_b <= BallB;
    end
    r_idx_p1 <= r_cnt_p0;
    r_oob_p1 <= w_oob;
    r_idx_p2 <= r_idx_p1;
    r_oob_p2 <= r_oob_p1;
    r_acc    <= w_acc_nxt;
  end

  assign map_addr = r_addr_p1;
  assign wLeft    = r_side[0];
  assign wRight   = r_side[1];
  assign wTop     = r_side[2];
  assign wBottom  = r_side[3];
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE) || r_done;

endmodule

// File: tb/tb_collision_probe.sv
// Randomized and directed bench for collision_probe with a tile-map ROM and reference model.
module tb_collision_probe;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  BallL = '0, BallR = '0, BallT = '0, BallB = '0;
  logic [10:0] map_addr;
  logic [2:0]  map_data = '0;
  logic [2:0]  wLeft, wRight, wTop, wBottom;
  logic        busy, done;

  logic [2:0] rom [0:2047];
  int n_chk = 0;
  int n_pass = 0;

  collision_probe dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .BallL    (BallL),
    .BallR    (BallR),
    .BallT    (BallT),
    .BallB    (BallB),
    .map_addr (map_addr),
    .map_data (map_data),
    .wLeft    (wLeft),
    .wRight   (wRight),
    .wTop     (wTop),
    .wBottom  (wBottom),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) map_data <= rom[map_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int tile_side(int t);
`ifdef COLLISION_HAZARD_EN
    case (t)
      0: return 1;
      2: return 2;
      3: return 3;
      4: return 4;
      default: return 0;
    endcase
`else
    if (t == 0 || (t >= 2 && t <= 4)) return 1;
    return 0;
`endif
  endfunction

  function automatic int probe_code(int x, int y);
    int xm, ym;
    xm = x & 1023;
    ym = y & 1023;
    if (xm >= 640 || ym >= 480) return 0;
    return tile_side(int'(rom[(ym / 16) * 40 + xm / 16]));
  endfunction

  function automatic int worst(int a, int b);
    int prio [5] = '{0, 3, 2, 4, 1};
    foreach (prio[i]) if (a == prio[i] || b == prio[i]) return prio[i];
    return 0;
  endfunction

  // side: 0 left, 1 right, 2 top, 3 bottom
  function automatic int exp_side(int s, int l, int r, int t, int b);
    case (s)
      0: return worst(probe_code(l - 1, t + 1), probe_code(l - 1, b - 1));
      1: return worst(probe_code(r + 1, t + 1), probe_code(r + 1, b - 1));
      2: return worst(probe_code(l + 1, t - 1), probe_code(r - 1, t - 1));
      default: return worst(probe_code(l + 1, b + 1), probe_code(r - 1, b + 1));
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 3'd0;
  endtask

  task automatic run_pass(input string tag, input int l, input int r, input int t, input int b,
                          input int restart_cyc);
    int e [4];
    int done_at, n_done;
    bit busy_ok;
    for (int s = 0; s < 4; s++) e[s] = exp_side(s, l, r, t, b);
    @(negedge Clk);
    BallL = 10'(l); BallR = 10'(r); BallT = 10'(t); BallB = 10'(b);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    BallL = 10'($urandom); BallR = 10'($urandom); BallT = 10'($urandom); BallB = 10'($urandom);
    done_at = -1;
    n_done = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge Clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (busy !== (c <= 10)) busy_ok = 1'b0;
      if (c == restart_cyc) start = 1'b1;
      if (c == restart_cyc + 1) start = 1'b0;
    end
    check({tag, " done_latency"}, 32'(done_at), 32'd10);
    check({tag, " done_count"}, 32'(n_done), 32'd1);
    check({tag, " busy_window"}, 32'(busy_ok), 32'd1);
    check({tag, " wLeft"},   32'(wLeft),   32'(e[0]));
    check({tag, " wRight"},  32'(wRight),  32'(e[1]));
    check({tag, " wTop"},    32'(wTop),    32'(e[2]));
    check({tag, " wBottom"}, 32'(wBottom), 32'(e[3]));
  endtask

  initial begin
    int l, r, t, b;
    clear_rom();
    #1;
    check("rst wLeft", 32'(wLeft), 32'd0);
    check("rst wBottom", 32'(wBottom), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst map_addr", 32'(map_addr), 32'd0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;

    for (int c = 0; c < 40; c++) rom[29 * 40 + c] = 3'd1;
    run_pass("floor", 20, 46, 435, 463, 0);
    check("floor wBottom_const", 32'(wBottom), 32'd0);
    check("floor wTop_const", 32'(wTop), 32'd1);

    clear_rom();
    run_pass("leftwrap", 0, 26, 200, 226, 0);
    check("leftwrap wLeft_const", 32'(wLeft), 32'd0);

    clear_rom();
    rom[29 * 40 + 5] = 3'd3;
    rom[29 * 40 + 6] = 3'd3;
    run_pass("lava", 80, 106, 435, 463, 0);
`ifdef COLLISION_HAZARD_EN
    check("lava wBottom_const", 32'(wBottom), 32'd3);
`else
    check("lava wBottom_const", 32'(wBottom), 32'd1);
`endif

    clear_rom();
    rom[29 * 40 + 5] = 3'd1;
    run_pass("restart", 80, 106, 435, 463, 2);

    // abort mid-pass with reset
    clear_rom();
    @(negedge Clk);
    BallL = 10'd300; BallR = 10'd326; BallT = 10'd100; BallB = 10'd126;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort wLeft", 32'(wLeft), 32'd0);
    check("abort wRight", 32'(wRight), 32'd0);
    check("abort wTop", 32'(wTop), 32'd0);
    check("abort wBottom", 32'(wBottom), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort map_addr", 32'(map_addr), 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge Clk); #1;
        if (done !== 1'b0) seen_done++;
      end
      check("abort no_done", 32'(seen_done), 32'd0);
    end
    Reset = 1'b1;
    run_pass("after_rst", 300, 326, 100, 126, 0);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 1200; i++) begin
        int k;
        k = int'($urandom_range(0, 11));
        rom[i] = (k < 5) ? 3'd0 : 3'(k - 4);
      end
      l = int'($urandom_range(0, 660));
      t = int'($urandom_range(0, 500));
      if (it % 5 == 0) l = 0;
      if (it % 7 == 3) t = 0;
      r = (l + int'($urandom_range(4, 60))) & 1023;
      b = (t + int'($urandom_range(4, 60))) & 1023;
      run_pass($sformatf("rnd%0d", it), l, r, t, b, (it % 4 == 1) ? 4 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/collision_probe.md
COLLISION_PROBE -- requirements
Module: collision_probe

Interface
REQ-001 SHALL have parameters: MAP_COLS default 40, tile columns per row; TILE_SHIFT default 4, log2 of tile size in pixels.
REQ-002 SHALL have port Clk, input, 1, the single pixel-domain clock.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, single-cycle request for one probe pass.
REQ-005 SHALL have ports BallL, BallR, BallT, BallB, input, 10 each, the character bounding box in pixels.
REQ-006 SHALL have port map_addr, output, 11, tile-map ROM address (row*MAP_COLS+col).
REQ-007 SHALL have port map_data, input, 3, tile code, valid one cycle after map_addr.
REQ-008 SHALL have ports wLeft, wRight, wTop, wBottom, output, 3 each, per-side contact code.
REQ-009 SHALL have port busy, output, 1, high while a pass is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the side codes update.

Function
REQ-011 SHALL use side codes 0 solid, 1 free, 2 water, 3 lava, 4 goo.
REQ-012 SHALL map tile codes 0 empty->1, 1 solid->0, 2 water->2, 3 lava->3, 4 goo->4, and 5-7 ->0.
REQ-013 SHALL use FSM states IDLE, PROBE, DRAIN, DONE: IDLE->PROBE on start; PROBE->DRAIN after 8 issues; DRAIN->DONE; DONE->IDLE.
REQ-014 SHALL latch BallL/R/T/B on the accepted start edge and ignore later box changes in the same pass.
REQ-015 SHALL issue one probe per PROBE cycle in this order: left (L-1,T+1), (L-1,B-1); right (R+1,T+1), (R+1,B-1); top (L+1,T-1), (R-1,T-1); bottom (L+1,B+1), (R-1,B+1).
REQ-016 SHALL compute probe coordinates modulo 2^10 and treat x>=640 or y>=480, including the 0-1 wrap to 1023, as solid without using map_data.
REQ-017 SHALL combine the two probes of a side with priority solid > lava > water > goo > free.
REQ-018 SHALL update all four side codes together, with done high for exactly one cycle, 10 cycles after the start-accepting edge.
REQ-019 SHALL assert busy from the cycle after start is accepted until the cycle done is high.
REQ-020 SHALL ignore start while busy, and SHALL NOT queue it.
REQ-021 SHALL hold the side codes stable between done pulses.

Reset
REQ-022 SHALL, on Reset low, asynchronously force state IDLE, all side codes 3'd0, busy 0, done 0, map_addr 0.
REQ-023 SHALL abort a pass in progress on Reset without a done pulse, and SHALL accept a new start on the first edge after release.

Configuration
REQ-024 SHALL honour macro COLLISION_HAZARD_EN: when defined, the tile mapping is as in REQ-012; when undefined, tile codes 2-4 report 1 (free) and only codes 0 and 1 are produced.

Structure
REQ-025 SHALL take the tile codes, side codes, TILE_SHIFT, MAP_COLS, screen limits 640/480 and the FSM state enum from shared package collision_pkg.
REQ-026 SHALL contain one sub-module, tile_addr_calc, combinational: pixel (x,y) -> map_addr via (row<<5)+(row<<3)+col, plus an out-of-bounds flag.

Verification
REQ-027 SHALL be verified with box L=20, R=46, T=435, B=463 and map row 29 solid, all else empty: start -> done 10 cycles later, wBottom=0, wLeft=wRight=wTop=1.
REQ-028 SHALL be verified with box L=0, R=26, T=200, B=226 in an empty map -> wLeft=0 (out-of-bounds wrap), others 1.
REQ-029 SHALL be verified with box L=80, R=106, B=463 and tiles (5,29),(6,29) lava -> wBottom=3 with COLLISION_HAZARD_EN, 1 without it.
REQ-030 SHALL be verified with start pulsed again 3 cycles after the first -> a single done pulse, busy high continuously, results from the first latched box.
REQ-031 SHALL be verified with Reset low 5 cycles into a pass -> no done, all side codes 0, busy 0; start after release -> done 10 cycles later.
